// File: rtl/cci_mpf_csrs_pkg.sv
// Shared types for the MPF CSR manager: VTP event indices, clear mask and
// 64-bit host-visible counter words.
package cci_mpf_csrs_pkg;

  localparam int NUM_VTP_EVENTS = 5;

  typedef enum logic [2:0] {
    E_4KB_HIT      = 3'd0,
    E_4KB_MISS     = 3'd1,
    E_2MB_HIT      = 3'd2,
    E_2MB_MISS     = 3'd3,
    E_PT_WALK_BUSY = 3'd4
  } t_cci_mpf_vtp_event_idx;

  typedef logic [NUM_VTP_EVENTS-1:0] t_cci_mpf_vtp_event_mask;
  typedef logic [63:0]               t_cci_mpf_vtp_event_ctr;

endpackage

// File: rtl/cci_mpf_event_counter.sv
// One VTP event counter with clear priority and freeze gating.
// CCI_MPF_VTP_EVENT_COUNTER_SATURATE_EN selects saturation plus a sticky flag in bit 63.
module cci_mpf_event_counter
  import cci_mpf_csrs_pkg::*;
#(
  parameter int COUNTER_BITS = 48
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   inc_i,
  input  logic                   freeze_i,
  input  logic                   clr_i,
  output t_cci_mpf_vtp_event_ctr value_o
);

  logic [COUNTER_BITS-1:0] cnt_q, cnt_d;
  logic                    do_inc;

  assign do_inc = inc_i & ~freeze_i;

`ifdef CCI_MPF_VTP_EVENT_COUNTER_SATURATE_EN
  logic sat_q, sat_d;

  // The flag records that at least one event was lost at the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr_i) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (do_inc) begin
      if (&cnt_q) sat_d = 1'b1;
      else        cnt_d = cnt_q + COUNTER_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign value_o = 64'(cnt_q) | {sat_q, 63'd0};
`else
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (do_inc) cnt_d = cnt_q + COUNTER_BITS'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign value_o = 64'(cnt_q);
`endif

endmodule

// File: rtl/cci_mpf_shim_vtp_event_counters.sv
// VTP event statistics: registered event inputs, one counter per event, indexed
// read with one-cycle latency and masked clear (see CCI_MPF_VTP_EVENT_COUNTER_SATURATE_EN).
module cci_mpf_shim_vtp_event_counters
  import cci_mpf_csrs_pkg::*;
#(
  parameter int COUNTER_BITS = 48,
  parameter int NUM_EVENTS   = NUM_VTP_EVENTS
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ev_4kb_hit,
  input  logic                    ev_4kb_miss,
  input  logic                    ev_2mb_hit,
  input  logic                    ev_2mb_miss,
  input  logic                    ev_pt_walk_busy,
  input  logic                    freeze,
  input  logic                    clr_valid,
  input  t_cci_mpf_vtp_event_mask clr_mask,
  input  logic                    rd_req_valid,
  input  logic [2:0]              rd_req_idx,
  output logic                    rd_rsp_valid,
  output t_cci_mpf_vtp_event_ctr  rd_rsp_data,
  output logic [2:0]              rd_rsp_idx
);

  if (NUM_EVENTS != NUM_VTP_EVENTS) begin : g_bad_num_events
    $error("NUM_EVENTS must equal NUM_VTP_EVENTS");
  end
`ifdef CCI_MPF_VTP_EVENT_COUNTER_SATURATE_EN
  if (COUNTER_BITS < 1 || COUNTER_BITS > 63) begin : g_bad_counter_bits
    $error("COUNTER_BITS must be 1..63 when saturating");
  end
`else
  if (COUNTER_BITS < 1 || COUNTER_BITS > 64) begin : g_bad_counter_bits
    $error("COUNTER_BITS must be 1..64");
  end
`endif

  t_cci_mpf_vtp_event_mask ev_d, ev_q;
  logic                    frz_q;
  t_cci_mpf_vtp_event_ctr  ctr_val [NUM_VTP_EVENTS];

  logic                    rsp_valid_q;
  t_cci_mpf_vtp_event_ctr  rsp_data_q, rsp_data_d;
  logic [2:0]              rsp_idx_q;

  always_comb begin
    ev_d                      = '0;
    ev_d[int'(E_4KB_HIT)]      = ev_4kb_hit;
    ev_d[int'(E_4KB_MISS)]     = ev_4kb_miss;
    ev_d[int'(E_2MB_HIT)]      = ev_2mb_hit;
    ev_d[int'(E_2MB_MISS)]     = ev_2mb_miss;
    ev_d[int'(E_PT_WALK_BUSY)] = ev_pt_walk_busy;
  end

  // Freeze travels with its events so it discards exactly the pulses it overlapped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ev_q  <= '0;
      frz_q <= 1'b0;
    end else begin
      ev_q  <= ev_d;
      frz_q <= freeze;
    end
  end

  for (genvar gi = 0; gi < NUM_VTP_EVENTS; gi++) begin : g_ctr
    cci_mpf_event_counter #(
      .COUNTER_BITS(COUNTER_BITS)
    ) u_ctr (
      .clk     (clk),
      .reset_n (reset_n),
      .inc_i   (ev_q[gi]),
      .freeze_i(frz_q),
      .clr_i   (clr_valid & clr_mask[gi]),
      .value_o (ctr_val[gi])
    );
  end

  always_comb begin
    rsp_data_d = '0;
    for (int i = 0; i < NUM_VTP_EVENTS; i++) begin
      if (rd_req_idx == 3'(i)) rsp_data_d = ctr_val[i];
    end
  end

  // Data and index hold between responses; only the valid bit pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_idx_q   <= '0;
    end else begin
      rsp_valid_q <= rd_req_valid;
      if (rd_req_valid) begin
        rsp_data_q <= rsp_data_d;
        rsp_idx_q  <= rd_req_idx;
      end
    end
  end

  assign rd_rsp_valid = rsp_valid_q;
  assign rd_rsp_data  = rsp_data_q;
  assign rd_rsp_idx   = rsp_idx_q;

endmodule

// File: tb/tb_cci_mpf_shim_vtp_event_counters.sv
// Directed bench for the VTP event counters, built with 4-bit counters so the
// wrap/saturation boundary is reachable in a few cycles.
module tb_cci_mpf_shim_vtp_event_counters;

  localparam int CB = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ev_4kb_hit = 1'b0, ev_4kb_miss = 1'b0, ev_2mb_hit = 1'b0;
  logic        ev_2mb_miss = 1'b0, ev_pt_walk_busy = 1'b0, freeze = 1'b0;
  logic        clr_valid = 1'b0;
  logic [4:0]  clr_mask = 5'd0;
  logic        rd_req_valid = 1'b0;
  logic [2:0]  rd_req_idx = 3'd0;
  logic        rd_rsp_valid;
  logic [63:0] rd_rsp_data;
  logic [2:0]  rd_rsp_idx;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  cci_mpf_shim_vtp_event_counters #(
    .COUNTER_BITS(CB),
    .NUM_EVENTS  (5)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ev_4kb_hit     (ev_4kb_hit),
    .ev_4kb_miss    (ev_4kb_miss),
    .ev_2mb_hit     (ev_2mb_hit),
    .ev_2mb_miss    (ev_2mb_miss),
    .ev_pt_walk_busy(ev_pt_walk_busy),
    .freeze         (freeze),
    .clr_valid      (clr_valid),
    .clr_mask       (clr_mask),
    .rd_req_valid   (rd_req_valid),
    .rd_req_idx     (rd_req_idx),
    .rd_rsp_valid   (rd_rsp_valid),
    .rd_rsp_data    (rd_rsp_data),
    .rd_rsp_idx     (rd_rsp_idx)
  );

  // Inputs change 1ns after the rising edge and outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rd_req_valid = 1'b1;
    rd_req_idx   = 3'd2;
    tick();
    tick();
    nvec++;
    if ({rd_rsp_valid, rd_rsp_idx, rd_rsp_data} !== 68'd0) begin
      nfail++;
      $display("FAIL reset_state: got valid=%b idx=%0d data=%h, expected all zero",
               rd_rsp_valid, rd_rsp_idx, rd_rsp_data);
    end
    rd_req_valid = 1'b0;
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      rd_req_valid = 1'b1;
      rd_req_idx   = 3'(i);
      tick();
      nvec++;
      if ({rd_rsp_valid, rd_rsp_idx, rd_rsp_data} !== {1'b1, 3'(i), 64'd0}) begin
        nfail++;
        $display("FAIL reset_read%0d: got valid=%b idx=%0d data=%h, expected 1/%0d/0",
                 i, rd_rsp_valid, rd_rsp_idx, rd_rsp_data, i);
      end
      $display("read idx %0d after reset -> %h", i, rd_rsp_data);
    end
    rd_req_valid = 1'b0;
    tick();
    nvec++;
    if (rd_rsp_valid !== 1'b0) begin
      nfail++;
      $display("FAIL reset_valid_drop: got valid=%b, expected 0", rd_rsp_valid);
    end
  endtask

  task automatic test_latency();
    ev_2mb_miss = 1'b1;                                   // t=10
    tick();
    rd_req_valid = 1'b1; rd_req_idx = 3'd3;               // t=11
    tick();
    nvec++;
    if ({rd_rsp_valid, rd_rsp_data} !== {1'b1, 64'd0}) begin
      nfail++;
      $display("FAIL latency_t11: got valid=%b data=%h, expected 1/0", rd_rsp_valid, rd_rsp_data);
    end
    tick();                                               // t=12 read
    nvec++;
    if ({rd_rsp_valid, rd_rsp_data} !== {1'b1, 64'd1}) begin
      nfail++;
      $display("FAIL latency_t12: got valid=%b data=%h, expected 1/1", rd_rsp_valid, rd_rsp_data);
    end
    ev_2mb_miss = 1'b0; rd_req_valid = 1'b0;              // t=13
    tick();
    rd_req_valid = 1'b1;                                  // t=14
    tick();
    nvec++;
    if ({rd_rsp_valid, rd_rsp_idx, rd_rsp_data} !== {1'b1, 3'd3, 64'd3}) begin
      nfail++;
      $display("FAIL latency_t14: got valid=%b idx=%0d data=%h, expected 1/3/3",
               rd_rsp_valid, rd_rsp_idx, rd_rsp_data);
    end
    $display("2mb_miss after 3 pulses -> %h", rd_rsp_data);
    rd_req_valid = 1'b0;
  endtask

  task automatic test_clear();
    logic [63:0] exp_other [5] = '{64'd0, 64'd0, 64'd0, 64'd3, 64'd0};
    for (int k = 0; k < 7; k++) begin
      ev_4kb_hit = 1'b1;
      tick();
    end
    ev_4kb_hit = 1'b0;
    tick();
    ev_4kb_hit = 1'b1; clr_valid = 1'b1; clr_mask = 5'b00001;
    rd_req_valid = 1'b1; rd_req_idx = 3'd0;
    tick();
    nvec++;
    if ({rd_rsp_valid, rd_rsp_data} !== {1'b1, 64'd7}) begin
      nfail++;
      $display("FAIL clear_pre_read: got valid=%b data=%h, expected 1/7", rd_rsp_valid, rd_rsp_data);
    end
    ev_4kb_hit = 1'b0; clr_valid = 1'b0; clr_mask = 5'd0;
    tick();
    nvec++;
    if (rd_rsp_data !== 64'd0) begin
      nfail++;
      $display("FAIL clear_next_read: got data=%h, expected 0", rd_rsp_data);
    end
    tick();
    nvec++;
    if (rd_rsp_data !== 64'd1) begin
      nfail++;
      $display("FAIL clear_event_counted: got data=%h, expected 1", rd_rsp_data);
    end
    $display("clear of idx 0 with concurrent event -> %h", rd_rsp_data);
    for (int i = 1; i < 5; i++) begin
      rd_req_idx = 3'(i);
      tick();
      nvec++;
      if ({rd_rsp_valid, rd_rsp_idx, rd_rsp_data} !== {1'b1, 3'(i), exp_other[i]}) begin
        nfail++;
        $display("FAIL clear_unmasked%0d: got valid=%b idx=%0d data=%h, expected 1/%0d/%h",
                 i, rd_rsp_valid, rd_rsp_idx, rd_rsp_data, i, exp_other[i]);
      end
    end
    rd_req_valid = 1'b0;
  endtask

  task automatic test_freeze();
    for (int k = 0; k < 20; k++) begin
      ev_pt_walk_busy = 1'b1;
      freeze          = (k >= 5 && k <= 9);
      rd_req_valid    = (k == 7);
      rd_req_idx      = 3'd4;
      tick();
      if (k == 7) begin
        nvec++;
        if ({rd_rsp_valid, rd_rsp_data} !== {1'b1, 64'd5}) begin
          nfail++;
          $display("FAIL freeze_mid_read: got valid=%b data=%h, expected 1/5", rd_rsp_valid, rd_rsp_data);
        end
      end
    end
    ev_pt_walk_busy = 1'b0; freeze = 1'b0; rd_req_valid = 1'b0;
    tick();
    tick();
    rd_req_valid = 1'b1; rd_req_idx = 3'd4;
    tick();
    nvec++;
    if ({rd_rsp_valid, rd_rsp_data} !== {1'b1, 64'd15}) begin
      nfail++;
      $display("FAIL freeze_total: got valid=%b data=%h, expected 1/15", rd_rsp_valid, rd_rsp_data);
    end
    $display("pt_walk_busy 20 cycles with 5 frozen -> %h", rd_rsp_data);
    rd_req_valid = 1'b0;
  endtask

  task automatic test_wrap();
    logic [63:0] exp_wrap;
`ifdef CCI_MPF_VTP_EVENT_COUNTER_SATURATE_EN
    exp_wrap = 64'h8000_0000_0000_000F;
`else
    exp_wrap = 64'd1;
`endif
    for (int k = 0; k < 17; k++) begin
      ev_4kb_miss = 1'b1;
      tick();
    end
    ev_4kb_miss = 1'b0;
    tick();
    tick();
    rd_req_valid = 1'b1; rd_req_idx = 3'd1;
    tick();
    nvec++;
    if ({rd_rsp_valid, rd_rsp_data} !== {1'b1, exp_wrap}) begin
      nfail++;
      $display("FAIL wrap_17: got valid=%b data=%h, expected 1/%h", rd_rsp_valid, rd_rsp_data, exp_wrap);
    end
    $display("4kb_miss after 17 pulses -> %h", rd_rsp_data);
    rd_req_valid = 1'b0; clr_valid = 1'b1; clr_mask = 5'b00010;
    tick();
    clr_valid = 1'b0; clr_mask = 5'd0;
    rd_req_valid = 1'b1; rd_req_idx = 3'd1;
    tick();
    nvec++;
    if (rd_rsp_data !== 64'd0) begin
      nfail++;
      $display("FAIL wrap_clear: got data=%h, expected 0", rd_rsp_data);
    end
    rd_req_idx = 3'd0;
    tick();
    nvec++;
    if (rd_rsp_data !== 64'd1) begin
      nfail++;
      $display("FAIL wrap_clear_isolation: got data=%h, expected 1", rd_rsp_data);
    end
    rd_req_valid = 1'b0;
  endtask

  task automatic test_bad_idx_and_hold();
    rd_req_valid = 1'b1; rd_req_idx = 3'd3;
    tick();
    rd_req_valid = 1'b0;
    tick();
    nvec++;
    if ({rd_rsp_valid, rd_rsp_idx, rd_rsp_data} !== {1'b0, 3'd3, 64'd3}) begin
      nfail++;
      $display("FAIL hold_data: got valid=%b idx=%0d data=%h, expected 0/3/3",
               rd_rsp_valid, rd_rsp_idx, rd_rsp_data);
    end
    for (int i = 5; i < 8; i++) begin
      rd_req_valid = 1'b1; rd_req_idx = 3'(i);
      tick();
      nvec++;
      if ({rd_rsp_valid, rd_rsp_idx, rd_rsp_data} !== {1'b1, 3'(i), 64'd0}) begin
        nfail++;
        $display("FAIL bad_idx%0d: got valid=%b idx=%0d data=%h, expected 1/%0d/0",
                 i, rd_rsp_valid, rd_rsp_idx, rd_rsp_data, i);
      end
      $display("read idx %0d -> %h", i, rd_rsp_data);
    end
    rd_req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    ev_2mb_hit = 1'b1; rd_req_valid = 1'b1; rd_req_idx = 3'd3;
    tick();
    nvec++;
    if ({rd_rsp_valid, rd_rsp_data} !== {1'b1, 64'd3}) begin
      nfail++;
      $display("FAIL midreset_pre: got valid=%b data=%h, expected 1/3", rd_rsp_valid, rd_rsp_data);
    end
    ev_2mb_hit = 1'b0; rd_req_idx = 3'd0;
    #2;
    reset_n = 1'b0;
    #1;
    nvec++;
    if ({rd_rsp_valid, rd_rsp_data} !== {1'b0, 64'd0}) begin
      nfail++;
      $display("FAIL midreset_async: got valid=%b data=%h, expected 0/0", rd_rsp_valid, rd_rsp_data);
    end
    rd_req_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    nvec++;
    if (rd_rsp_valid !== 1'b0) begin
      nfail++;
      $display("FAIL midreset_no_pending: got valid=%b, expected 0", rd_rsp_valid);
    end
    for (int i = 0; i < 5; i++) begin
      rd_req_valid = 1'b1; rd_req_idx = 3'(i);
      tick();
      nvec++;
      if ({rd_rsp_valid, rd_rsp_idx, rd_rsp_data} !== {1'b1, 3'(i), 64'd0}) begin
        nfail++;
        $display("FAIL midreset_read%0d: got valid=%b idx=%0d data=%h, expected 1/%0d/0",
                 i, rd_rsp_valid, rd_rsp_idx, rd_rsp_data, i);
      end
    end
    rd_req_valid = 1'b0;
    tick();
  endtask

  initial begin
    tick();
    test_reset();
    test_latency();
    test_clear();
    test_freeze();
    test_wrap();
    test_bad_idx_and_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
